// File: rtl/dfp_mul_seq.sv
// dfp_mul_seq: sequential BCD decimal floating-point multiplier, one b digit per ce cycle.
// Define DFPMUL_EARLY_OUT_EN to skip the digit loop for zero, NaN, inf and over/underflow operands.
module dfp_mul_seq #(
  parameter int N    = 25,
  parameter int EW   = 12,
  parameter int BIAS = 1535,
  parameter int EMAX = 3071
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ce,
  input  logic           ld,
  input  logic           a_sign,
  input  logic           b_sign,
  input  logic [EW-1:0]  a_exp,
  input  logic [EW-1:0]  b_exp,
  input  logic [4*N-1:0] a_sig,
  input  logic [4*N-1:0] b_sig,
  input  logic           a_inf,
  input  logic           b_inf,
  input  logic           a_nan,
  input  logic           b_nan,
  input  logic           a_snan,
  input  logic           b_snan,
  output logic           o_sign,
  output logic [EW-1:0]  o_exp,
  output logic [8*N-1:0] o_sig,
  output logic           o_inf,
  output logic           o_nan,
  output logic           overflow,
  output logic           underflow,
  output logic           invalid,
  output logic           busy,
  output logic           done
);
  localparam int CW = $clog2(N);
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  state_t state, nxt;
  logic [4*N-1:0] a_q, b_q, b_rot, ca_sig, cb_sig;
  logic [EW-1:0] ae_q, be_q, ca_exp, cb_exp, r_exp;
  logic an_q, bn_q, ai_q, bi_q, sn_q, sg_q;
  logic [8*N+3:0] acc, acc_nxt;
  logic [4*N+3:0] a_x, sum;
  logic [CW-1:0] cnt;
  logic [3:0] dig;
  logic [EW+1:0] e;
  logic [8*N-1:0] r_sig;
  logic mul, accept, last, fin, early;
  logic an, bn, ai, bi, sn, sg, az, bz, ov, un, i0, r_nan, r_inf, r_ovf, r_unf;

  assign mul    = state == MUL;
  assign accept = ld && !mul;
  assign last   = mul && cnt == '0;
  assign fin    = last || early;
  // b rotates instead of shifting so the original b_sig is back in place for a NaN payload
  assign b_rot  = {b_q[3:0], b_q[4*N-1:4]};
  assign dig    = b_q[3:0];
  assign a_x    = {4'h0, a_q};

  // upper N+1 digits of acc plus a*dig, digit-serial BCD carry chain
  always_comb begin
    logic [7:0] p;
    logic [5:0] s, t;
    logic [1:0] c;
    sum = '0;
    p = '0;
    s = '0;
    t = '0;
    c = '0;
    for (int i = 0; i <= N; i++) begin
      p = 8'(a_x[4*i+:4]) * 8'(dig);
      s = 6'(acc[4*(N+i)+:4]) + 6'(p % 8'd10) + t + 6'(c);
      t = 6'(p / 8'd10);
      c = s >= 6'd20 ? 2'd2 : s >= 6'd10 ? 2'd1 : 2'd0;
      sum[4*i+:4] = 4'(s - 6'(c) * 6'd10);
    end
  end
  assign acc_nxt = {4'h0, sum, acc[4*N-1:4]};

  // classification runs on live inputs at acceptance (early-out) and on latched operands in MUL
  assign ca_sig = mul ? a_q : a_sig;
  assign cb_sig = mul ? b_rot : b_sig;
  assign ca_exp = mul ? ae_q : a_exp;
  assign cb_exp = mul ? be_q : b_exp;
  assign an     = mul ? an_q : a_nan || a_snan;
  assign bn     = mul ? bn_q : b_nan || b_snan;
  assign ai     = mul ? ai_q : a_inf;
  assign bi     = mul ? bi_q : b_inf;
  assign sn     = mul ? sn_q : a_snan || b_snan;
  assign sg     = mul ? sg_q : a_sign ^ b_sign;
  assign e      = {2'b0, ca_exp} + {2'b0, cb_exp} - (EW+2)'(BIAS);
  assign un     = e[EW+1];
  assign ov     = !un && e[EW:0] >= (EW+1)'(EMAX);
  assign az     = !ai && ca_sig == '0;
  assign bz     = !bi && cb_sig == '0;
  assign i0     = (ai && bz) || (bi && az);
  assign r_nan  = an || bn || i0;
  assign r_inf  = !r_nan && (ai || bi || ov);
  assign r_ovf  = !r_nan && !ai && !bi && ov;
  assign r_unf  = !r_nan && !ai && !bi && un;
  assign r_exp  = (r_nan || r_inf) ? EW'(EMAX) : r_unf ? '0 : e[EW-1:0];
  assign r_sig  = an ? {ca_sig, {4*N{1'b0}}} :
                  bn ? {cb_sig, {4*N{1'b0}}} :
                  i0 ? {4'h1, {8*N-4{1'b0}}} :
                  (r_inf || r_unf || !mul) ? '0 : acc_nxt[8*N-1:0];

`ifdef DFPMUL_EARLY_OUT_EN
  assign early = accept && (an || bn || ai || bi || az || bz || ov || un);
`else
  assign early = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else if (ce) state <= nxt;

  always_comb
    nxt = accept ? (early ? DONE : MUL) : last ? DONE : state;

  always_comb begin
    busy = mul;
    done = state == DONE;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      ae_q <= '0;
      be_q <= '0;
      an_q <= 1'b0;
      bn_q <= 1'b0;
      ai_q <= 1'b0;
      bi_q <= 1'b0;
      sn_q <= 1'b0;
      sg_q <= 1'b0;
      acc <= '0;
      cnt <= '0;
      o_sign <= 1'b0;
      o_exp <= '0;
      o_sig <= '0;
      o_inf <= 1'b0;
      o_nan <= 1'b0;
      overflow <= 1'b0;
      underflow <= 1'b0;
      invalid <= 1'b0;
    end else if (ce) begin
      if (accept) begin
        a_q <= a_sig;
        b_q <= b_sig;
        ae_q <= a_exp;
        be_q <= b_exp;
        an_q <= a_nan || a_snan;
        bn_q <= b_nan || b_snan;
        ai_q <= a_inf;
        bi_q <= b_inf;
        sn_q <= a_snan || b_snan;
        sg_q <= a_sign ^ b_sign;
        acc <= '0;
        cnt <= CW'(N - 1);
      end else if (mul) begin
        acc <= acc_nxt;
        b_q <= b_rot;
        cnt <= cnt - CW'(1);
      end
      if (fin) begin
        o_sign <= sg;
        o_exp <= r_exp;
        o_sig <= r_sig;
        o_inf <= r_inf;
        o_nan <= r_nan;
        overflow <= r_ovf;
        underflow <= r_unf;
        invalid <= sn || i0;
      end
    end
endmodule

// File: tb/tb_dfp_mul_seq.sv
// tb_dfp_mul_seq: directed self-checking bench for dfp_mul_seq at default parameters.
module tb_dfp_mul_seq;
  localparam int N = 25;
`ifdef DFPMUL_EARLY_OUT_EN
  localparam int LAT0 = 1;
`else
  localparam int LAT0 = 26;
`endif
  logic clk = 1'b0, rst_n = 1'b0, ce = 1'b1, ld = 1'b0;
  logic a_sign = 1'b0, b_sign = 1'b0, a_inf = 1'b0, b_inf = 1'b0;
  logic a_nan = 1'b0, b_nan = 1'b0, a_snan = 1'b0, b_snan = 1'b0;
  logic [11:0] a_exp = '0, b_exp = '0;
  logic [4*N-1:0] a_sig = '0, b_sig = '0;
  logic [4*N-1:0] nines = {N{4'h9}};
  logic o_sign, o_inf, o_nan, overflow, underflow, invalid, busy, done;
  logic [11:0] o_exp;
  logic [8*N-1:0] o_sig;
  int n_chk = 0, n_fail = 0, lat;
  logic bsy, saw;

  always #5 clk = ~clk;

  dfp_mul_seq dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .ld(ld),
    .a_sign(a_sign), .b_sign(b_sign), .a_exp(a_exp), .b_exp(b_exp),
    .a_sig(a_sig), .b_sig(b_sig), .a_inf(a_inf), .b_inf(b_inf),
    .a_nan(a_nan), .b_nan(b_nan), .a_snan(a_snan), .b_snan(b_snan),
    .o_sign(o_sign), .o_exp(o_exp), .o_sig(o_sig), .o_inf(o_inf), .o_nan(o_nan),
    .overflow(overflow), .underflow(underflow), .invalid(invalid),
    .busy(busy), .done(done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic res(input string tag, input logic [5:0] f, input logic [11:0] ex, input logic [8*N-1:0] sg);
    chk({tag, "_flags"}, {busy, done, o_sign, o_inf, o_nan, overflow, underflow, invalid}, {2'b01, f});
    chk({tag, "_exp"}, o_exp, ex);
    chk({tag, "_sig"}, o_sig, sg);
  endtask

  task automatic set_op(input logic as, input int ae, input logic [4*N-1:0] asg,
                        input logic bs, input int be, input logic [4*N-1:0] bsg);
    a_sign = as; a_exp = 12'(ae); a_sig = asg;
    b_sign = bs; b_exp = 12'(be); b_sig = bsg;
    {a_inf, b_inf, a_nan, b_nan, a_snan, b_snan} = '0;
  endtask

  task automatic go(input int stall_at, input int reld_at, output int n, output logic bs);
    ld = 1'b1;
    tick;
    ld = 1'b0;
    n = 1;
    bs = busy;
    while (!done && n < 200) begin
      if (n == reld_at) begin
        ld = 1'b1;
        a_sig = nines;
        b_sig = nines;
        a_exp = 12'd100;
        b_exp = 12'd100;
      end
      if (n == stall_at) ce = 1'b0;
      if (n == stall_at + 3) ce = 1'b1;
      tick;
      n++;
      ld = 1'b0;
    end
  endtask

  initial begin
    tick;
    tick;
    chk("reset_flags", {busy, done, o_sign, o_inf, o_nan, overflow, underflow, invalid}, 8'h00);
    chk("reset_data", {o_exp, o_sig}, '0);
    rst_n = 1'b1;
    tick;

    set_op(1, 1535, 100'h2, 0, 1535, 100'h3);
    go(0, 0, lat, bsy);
    chk("basic_busy", bsy, 1'b1);
    chk("basic_lat", lat, 26);
    res("basic", 6'b100000, 12'd1535, 200'h6);

    set_op(1, 1535, nines, 1, 1535, nines);
    go(0, 0, lat, bsy);
    chk("nines_lat", lat, 26);
    res("nines", 6'b000000, 12'd1535, {{24{4'h9}}, 4'h8, {24{4'h0}}, 4'h1});

    set_op(0, 1600, 100'h12345678, 1, 1500, 100'h87654321);
    go(0, 0, lat, bsy);
    res("mixed", 6'b100000, 12'd1565, 200'h1082152022374638);

    set_op(0, 3071, 100'h0, 1, 0, 100'h0);
    a_inf = 1'b1;
    go(0, 0, lat, bsy);
    chk("infzero_lat", lat, LAT0);
    res("infzero", 6'b101001, 12'd3071, {4'h1, 196'h0});

    set_op(0, 3000, 100'h5, 0, 3000, 100'h7);
    go(0, 0, lat, bsy);
    res("ovf", 6'b010100, 12'd3071, 200'h0);

    set_op(1, 100, 100'h5, 1, 100, 100'h7);
    go(0, 0, lat, bsy);
    res("unf", 6'b000010, 12'd0, 200'h0);

    set_op(0, 2000, 100'h4, 0, 2606, 100'h2);
    go(0, 0, lat, bsy);
    res("emax_ovf", 6'b010100, 12'd3071, 200'h0);

    set_op(0, 2000, 100'h4, 0, 2605, 100'h2);
    go(0, 0, lat, bsy);
    res("emax_m1", 6'b000000, 12'd3070, 200'h8);

    set_op(0, 0, 100'h3, 0, 1535, 100'h3);
    go(0, 0, lat, bsy);
    res("exp_zero", 6'b000000, 12'd0, 200'h9);

    set_op(1, 0, 100'h123, 0, 0, 100'h456);
    a_nan = 1'b1;
    b_snan = 1'b1;
    go(0, 0, lat, bsy);
    res("anan", 6'b101001, 12'd3071, {100'h123, 100'h0});

    set_op(0, 1535, 100'h5, 0, 1535, 100'h456);
    b_snan = 1'b1;
    go(0, 0, lat, bsy);
    res("bsnan", 6'b001001, 12'd3071, {100'h456, 100'h0});

    set_op(0, 10, 100'h5, 1, 3071, 100'h0);
    b_inf = 1'b1;
    go(0, 0, lat, bsy);
    res("inf", 6'b110000, 12'd3071, 200'h0);

    set_op(0, 1535, 100'h12345678, 0, 1535, 100'h87654321);
    go(0, 4, lat, bsy);
    chk("reld_lat", lat, 26);
    res("reld", 6'b000000, 12'd1535, 200'h1082152022374638);

    set_op(0, 1535, 100'h2, 0, 1535, 100'h3);
    ld = 1'b1;
    tick;
    ld = 1'b0;
    repeat (8) tick;
    rst_n = 1'b0;
    #1;
    chk("abort_flags", {busy, done, o_sign, o_inf, o_nan, overflow, underflow, invalid}, 8'h00);
    chk("abort_data", {o_exp, o_sig}, '0);
    tick;
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (30) begin
      tick;
      saw |= done | busy;
    end
    chk("abort_quiet", saw, 1'b0);

    go(0, 0, lat, bsy);
    chk("post_rst_lat", lat, 26);
    res("post_rst", 6'b000000, 12'd1535, 200'h6);

    set_op(0, 1535, 100'h12345678, 1, 1535, 100'h87654321);
    go(10, 0, lat, bsy);
    chk("stall_lat", lat, 29);
    res("stall", 6'b100000, 12'd1535, 200'h1082152022374638);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
